// File: rtl/fetch_stage.sv
// fetch_stage: pipeline front end. Owns the PC register and the IF/ID latch.
//   CLK, nRST          : clock and synchronous active-low reset
//   stall_PC           : hold PC this cycle
//   stall_IFID         : hold IF/ID latch this cycle
//   flush_IFID         : replace IF/ID contents with a bubble
//   redirect_valid/pc  : taken branch/jump target from EX/MEM
//   ihit, iload        : instruction memory response
//   halt               : HALT retired downstream; stop fetching
//   imemREN, imemaddr  : instruction memory request (address is the PC)
//   IFID_instr/pcplus4/valid : IF/ID latch presented to decode
//   halted             : fetch stopped by halt
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter int unsigned WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              stall_PC,
  input  logic              stall_IFID,
  input  logic              flush_IFID,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  input  logic              halt,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] IFID_instr,
  output logic [WORD_W-1:0] IFID_pcplus4,
  output logic              IFID_valid,
  output logic              halted
);

  localparam logic ST_FETCH  = 1'b0;
  localparam logic ST_HALTED = 1'b1;

  logic              state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [WORD_W-1:0] pend_pc_q, pend_pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pcplus4_q, pcplus4_d;
  logic              valid_q, valid_d;

  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] redir_aligned;
  logic              fetching;
  logic              steering;

  assign pc_plus4      = pc_q + WORD_W'(4);
  assign redir_aligned = {redirect_pc[WORD_W-1:2], 2'b00};
  assign fetching      = (state_q == ST_FETCH);
  // The PC is being pointed at a new target this cycle; whatever memory
  // returned for the old PC is wrong-path and must not enter IF/ID.
  assign steering      = fetching && !halt && !stall_PC && (redirect_valid || pend_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (fetching) begin
      if (halt) begin
        state_d = ST_HALTED;
      end else if (stall_PC) begin
        // Remember the redirect so it is applied once the stall drops.
        if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redir_aligned;
        end
      end else if (redirect_valid) begin
        pc_d   = redir_aligned;
        pend_d = 1'b0;
      end else if (pend_q) begin
        pc_d   = pend_pc_q;
        pend_d = 1'b0;
      end else if (ihit) begin
        pc_d = pc_plus4;
      end
    end
  end

  always_comb begin
    instr_d   = '0;
    pcplus4_d = '0;
    valid_d   = 1'b0;
    if (flush_IFID) begin
      instr_d   = '0;
    end else if (stall_IFID) begin
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
    end else if (!fetching || halt) begin
      instr_d   = '0;
    end else if (ihit && !steering && !stall_PC) begin
      instr_d   = iload;
      pcplus4_d = pc_plus4;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= ST_FETCH;
      pc_q      <= PC_INIT;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      instr_q   <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign imemREN      = fetching;
  assign halted       = (state_q == ST_HALTED);
  assign imemaddr     = pc_q;
  assign IFID_instr   = instr_q;
  assign IFID_pcplus4 = pcplus4_q;
  assign IFID_valid   = valid_q;

endmodule
